// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - line refill and writeback engine between data cache and memory
//
// On a cache miss this block optionally writes back a dirty victim line and
// then fetches the missing line, one word per beat over a req/ack memory
// bus, returning the assembled line with a one-cycle response pulse.
//
// Ports:
//   clk, rst             clock and asynchronous active-low reset
//   i_miss, i_miss_addr  miss request (level, held until response) and byte address
//   i_evict              dirty victim present (only meaningful with i_miss)
//   i_evict_addr/_data   victim line address and data
//   o_memory_line        filled line returned to the cache
//   o_memory_response    one-cycle pulse: o_memory_line is valid
//   o_busy               high whenever the engine is not idle
//   o_mem_req/_we        beat request, 1 = write beat
//   o_mem_addr/_wdata    word-aligned beat address and write data
//   i_mem_ack            beat completes in the cycle this is high
//   i_mem_rdata          read data, valid with i_mem_ack on a read beat

module cache_refill_ctrl #(
    parameter int LINE_BITS = 512,
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_miss,
    input  logic [ADDR_BITS-1:0] i_miss_addr,
    input  logic                 i_evict,
    input  logic [ADDR_BITS-1:0] i_evict_addr,
    input  logic [LINE_BITS-1:0] i_evict_data,
    output logic [LINE_BITS-1:0] o_memory_line,
    output logic                 o_memory_response,
    output logic                 o_busy,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [ADDR_BITS-1:0] o_mem_addr,
    output logic [WORD_BITS-1:0] o_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [WORD_BITS-1:0] i_mem_rdata
);

    localparam int BEATS    = LINE_BITS / WORD_BITS;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_OFF = $clog2(WORD_BITS / 8);

    // Mask clearing the byte-within-line bits of an address.
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(LINE_BITS / 8 - 1);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [ADDR_BITS-1:0]   miss_base_q;
    logic [ADDR_BITS-1:0]   evict_base_q;
    logic [LINE_BITS-1:0]   evict_data_q;
    logic [LINE_BITS-1:0]   line_q;
    logic [ADDR_BITS-1:0]   beat_offset;
    logic                   last_beat;
    logic                   accept_miss;

    assign last_beat   = (beat_q == LAST_BEAT);
    assign accept_miss = (state_q == IDLE) && i_miss;
    // Offset within the line never exceeds the line size, so adding it to an
    // aligned base cannot carry into the tag bits.
    assign beat_offset = ADDR_BITS'({beat_q, {WORD_OFF{1'b0}}});

    // State, beat counter and all latched request data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            miss_base_q  <= '0;
            evict_base_q <= '0;
            evict_data_q <= '0;
            line_q       <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            // Everything the transfer needs is captured here, so the cache
            // may change its miss/evict inputs freely once we leave IDLE.
            if (accept_miss) begin
                miss_base_q  <= i_miss_addr & LINE_MASK;
                evict_base_q <= i_evict_addr & LINE_MASK;
                evict_data_q <= i_evict_data;
            end
            if ((state_q == FILL) && i_mem_ack) begin
                line_q[beat_q*WORD_BITS +: WORD_BITS] <= i_mem_rdata;
            end
        end
    end

    // Next-state and beat counter.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (i_miss) begin
                    beat_d  = '0;
                    state_d = i_evict ? WB : FILL;
                end
            end
            WB: begin
                if (i_mem_ack) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = FILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FILL: begin
                if (i_mem_ack) begin
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Bus and cache outputs decode only registered state, so they hold steady
    // through stalls and a reset pulls o_mem_req low without waiting for a clock.
    always_comb begin
        o_busy            = (state_q != IDLE);
        o_memory_response = (state_q == RESP);
        o_memory_line     = line_q;
        o_mem_req         = 1'b0;
        o_mem_we          = 1'b0;
        o_mem_addr        = '0;
        o_mem_wdata       = '0;
        case (state_q)
            WB: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = evict_base_q + beat_offset;
                o_mem_wdata = evict_data_q[beat_q*WORD_BITS +: WORD_BITS];
            end
            FILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = miss_base_q + beat_offset;
            end
            default: begin
                o_mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - scoreboard bench for cache_refill_ctrl

module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst;
    logic         i_miss;
    logic [31:0]  i_miss_addr;
    logic         i_evict;
    logic [31:0]  i_evict_addr;
    logic [511:0] i_evict_data;
    logic [511:0] o_memory_line;
    logic         o_memory_response;
    logic         o_busy;
    logic         o_mem_req;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_ack;
    logic [31:0]  i_mem_rdata;

    cache_refill_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .i_miss            (i_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_busy            (o_busy),
        .o_mem_req         (o_mem_req),
        .o_mem_we          (o_mem_we),
        .o_mem_addr        (o_mem_addr),
        .o_mem_wdata       (o_mem_wdata),
        .i_mem_ack         (i_mem_ack),
        .i_mem_rdata       (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t        exp_q[$];
    logic [511:0] exp_line;
    int           errors = 0;
    int           checks = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_evict_data();
        for (int k = 0; k < 16; k++) i_evict_data[32*k +: 32] = $urandom;
    endtask

    // Drive a miss and push the expected bus beats and returned line.
    task automatic start_miss(input logic [31:0] maddr, input logic ev, input logic [31:0] eaddr,
                              input logic [31:0] wbase, input logic [31:0] rbase);
        beat_t b;
        i_miss       = 1'b1;
        i_miss_addr  = maddr;
        i_evict      = ev;
        i_evict_addr = eaddr;
        for (int k = 0; k < 16; k++) begin
            i_evict_data[32*k +: 32] = ev ? (wbase + k) : $urandom;
            if (ev) begin
                b.we   = 1'b1;
                b.addr = {eaddr[31:6], 6'b0} + 32'(4*k);
                b.data = wbase + k;
                exp_q.push_back(b);
            end
        end
        for (int k = 0; k < 16; k++) begin
            b.we   = 1'b0;
            b.addr = {maddr[31:6], 6'b0} + 32'(4*k);
            b.data = rbase + k;
            exp_q.push_back(b);
            exp_line[32*k +: 32] = rbase + k;
        end
    endtask

    // Cycle 1 is the first cycle after the miss is sampled. Returns at the
    // negedge of the IDLE cycle after the response, or at the abort point.
    task automatic run_txn(input int ack_every, input int exp_cycle, input int abort_after);
        int    cyc;
        int    acks;
        int    w;
        bit    done;
        bit    ack;
        beat_t e;
        cyc  = 0;
        acks = 0;
        w    = 0;
        done = 0;
        @(posedge clk);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (cyc == 1) begin
                i_miss_addr  = $urandom;
                i_evict      = 1'($urandom);
                i_evict_addr = $urandom;
                randomize_evict_data();
            end
            if (abort_after >= 0 && acks == abort_after) begin
                i_mem_ack = 1'b0;
                done      = 1;
            end else if (o_memory_response) begin
                check_eq("resp_cycle", cyc, exp_cycle);
                check_eq("resp_line", o_memory_line, exp_line);
                check_eq("beats_left", exp_q.size(), 0);
                i_miss    = 1'b0;
                i_mem_ack = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_eq("resp_one_cycle", o_memory_response, 1'b0);
                check_eq("busy_after_resp", o_busy, 1'b0);
                check_eq("req_after_resp", o_mem_req, 1'b0);
                check_eq("line_hold", o_memory_line, exp_line);
                done = 1;
            end else begin
                if (!o_mem_req) begin
                    check_eq("req_during_xfer", o_mem_req, 1'b1);
                    i_mem_ack = 1'b0;
                end else if (exp_q.size() == 0) begin
                    check_eq("extra_beat", exp_q.size(), 1);
                    i_mem_ack = 1'b0;
                end else begin
                    e = exp_q[0];
                    check_eq("beat_we", o_mem_we, e.we);
                    check_eq("beat_addr", o_mem_addr, e.addr);
                    if (e.we) check_eq("beat_wdata", o_mem_wdata, e.data);
                    ack = (w == ack_every - 1);
                    if (ack) begin
                        w           = 0;
                        acks++;
                        i_mem_rdata = e.we ? $urandom : e.data;
                        void'(exp_q.pop_front());
                    end else begin
                        w++;
                        i_mem_rdata = $urandom;
                    end
                    i_mem_ack = ack;
                end
                @(posedge clk);
                cyc++;
            end
        end
        if (!done) check_eq("txn_timeout", cyc, exp_cycle);
    endtask

    initial begin
        rst          = 1'b0;
        i_miss       = 1'b0;
        i_miss_addr  = '0;
        i_evict      = 1'b0;
        i_evict_addr = '0;
        i_evict_data = '0;
        i_mem_ack    = 1'b0;
        i_mem_rdata  = '0;
        exp_line     = '0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_miss       = 1'($urandom);
            i_miss_addr  = $urandom;
            i_evict      = 1'($urandom);
            i_evict_addr = $urandom;
            randomize_evict_data();
            i_mem_ack    = 1'($urandom);
            i_mem_rdata  = $urandom;
        end
        #1;
        check_eq("rst_line", o_memory_line, '0);
        check_eq("rst_resp", o_memory_response, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_req", o_mem_req, 1'b0);
        check_eq("rst_we", o_mem_we, 1'b0);
        check_eq("rst_addr", o_mem_addr, '0);
        check_eq("rst_wdata", o_mem_wdata, '0);

        @(negedge clk);
        i_miss    = 1'b0;
        i_mem_ack = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", o_busy, 1'b0);
        check_eq("idle_req", o_mem_req, 1'b0);

        // Clean fill.
        start_miss(32'h0000_1234, 1'b0, 32'h0, 32'h0, 32'hA000_0000);
        run_txn(1, 17, -1);

        // Back-to-back miss in the first IDLE cycle after RESP.
        check_eq("b2b_idle_busy", o_busy, 1'b0);
        start_miss(32'h0000_2048, 1'b0, 32'h0, 32'h0, 32'hB000_0000);
        run_txn(1, 17, -1);

        // Stray ack while idle.
        i_mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_mem_ack = 1'b0;
        check_eq("stray_busy", o_busy, 1'b0);
        check_eq("stray_req", o_mem_req, 1'b0);

        // Dirty fill: writeback then fill.
        start_miss(32'h0000_0080, 1'b1, 32'h0004_0040, 32'h5A5A_0000, 32'hC000_0000);
        run_txn(1, 33, -1);

        // Wait states: ack every third cycle.
        start_miss(32'h0001_00C4, 1'b0, 32'h0, 32'h0, 32'hD000_0000);
        run_txn(3, 49, -1);

        // Reset after beat 7 of a fill.
        start_miss(32'h0000_3000, 1'b0, 32'h0, 32'h0, 32'hE000_0000);
        run_txn(1, 17, 8);
        rst = 1'b0;
        #1;
        check_eq("abort_req", o_mem_req, 1'b0);
        check_eq("abort_busy", o_busy, 1'b0);
        i_miss = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check_eq("abort_no_resp", o_memory_response, 1'b0);
            check_eq("abort_line", o_memory_line, '0);
        end
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_idle", o_busy, 1'b0);

        // Fresh miss after the abort, with a writeback.
        start_miss(32'h0000_3010, 1'b1, 32'h0000_7FC0, 32'h1234_0000, 32'hF000_0000);
        run_txn(1, 33, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Line refill and writeback engine between the set-associative data cache and main memory. On a cache miss it writes back the evicted dirty line if there is one, then fetches the missing 512-bit line as 16 word beats over a 32-bit req/ack memory bus. It returns the assembled line to the cache with a one-cycle response pulse. It sits directly downstream of the data cache's miss/evict outputs and drives the cache's memory-line and memory-response inputs.

## Interface
- LINE_BITS, 512, cache line width; must be a multiple of WORD_BITS.
- WORD_BITS, 32, memory bus data width.
- ADDR_BITS, 32, byte address width.
- BEATS, LINE_BITS/WORD_BITS (16), beats per line; derived, not overridden.

- clk  in  1  system clock; one clock domain, all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-low.
- i_miss  in  1  cache miss request; level, held until o_memory_response.
- i_miss_addr  in  ADDR_BITS  byte address of the missing access.
- i_evict  in  1  a dirty victim must be written back; qualified by i_miss.
- i_evict_addr  in  ADDR_BITS  victim line address.
- i_evict_data  in  LINE_BITS  victim line data.
- o_memory_line  out  LINE_BITS  filled line to cache.
- o_memory_response  out  1  one-cycle pulse: o_memory_line is valid.
- o_busy  out  1  high in every state except IDLE.
- o_mem_req  out  1  memory beat request.
- o_mem_we  out  1  1 = write beat, 0 = read beat.
- o_mem_addr  out  ADDR_BITS  word-aligned beat address.
- o_mem_wdata  out  WORD_BITS  write data for the beat.
- i_mem_ack  in  1  beat accepted/completed this cycle.
- i_mem_rdata  in  WORD_BITS  read data, valid when i_mem_ack=1 on a read beat.

## Operation
- States: IDLE, WB, FILL, RESP.
- IDLE: if i_miss=1, latch the line bases {i_miss_addr[31:6],6'b0} and {i_evict_addr[31:6],6'b0}, latch i_evict_data, and clear the beat counter.
  - Go to WB if i_evict=1, otherwise to FILL.
  - i_evict without i_miss is ignored.
- WB: o_mem_req=1, o_mem_we=1, o_mem_addr = evict base + 4*beat, o_mem_wdata = latched line bits [32*beat+31 : 32*beat].
  - Each i_mem_ack increments the 4-bit beat counter.
  - The ack on beat 15 moves to FILL with the counter cleared to 0.
- FILL: o_mem_req=1, o_mem_we=0, o_mem_addr = miss base + 4*beat.
  - On i_mem_ack, capture i_mem_rdata into o_memory_line bits [32*beat+31 : 32*beat] and increment the counter.
  - The ack on beat 15 moves to RESP.
- RESP: o_memory_response=1 for exactly one cycle, then return to IDLE.
- Address arithmetic: base + {beat,2'b00}. The offset never exceeds 60, so there is no carry out of the line.
- Word order: beat k maps to bits [32k+31:32k]; beat 0 is the lowest address.
- o_memory_line keeps its value after RESP until FILL beats of the next request overwrite it.
- i_mem_ack outside WB/FILL is ignored. Changes on i_miss, i_miss_addr and i_evict_* outside IDLE are ignored, because all values are latched.
- Cache contract: i_miss is deasserted in the cycle after o_memory_response. The controller accepts a new miss in any IDLE cycle.

## Timing
- Reset (rst=0, asynchronous): state IDLE, counter 0, and all outputs 0 (o_memory_line, o_memory_response, o_busy, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata). Latched addresses and data are cleared.
- Reset mid-transfer aborts it immediately: o_mem_req drops asynchronously, the partial line is discarded, and no response is given.
- Bus handshake:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are registered and stay stable while o_mem_req=1 and i_mem_ack=0.
  - A beat completes in the cycle i_mem_ack=1.
  - The next beat's address/data are presented in the following cycle with o_mem_req still high, so back-to-back beats are allowed.
- o_mem_req is deasserted in RESP and IDLE.
- Latency with the miss sampled in cycle 0 and i_mem_ack tied high:
  - No evict: FILL occupies cycles 1–16 and o_memory_response is in cycle 17.
  - With evict: WB occupies 1–16, FILL 17–32, and the response is in cycle 33.
- Each wait cycle on the bus adds exactly one cycle.
- o_busy rises in the cycle after the miss is sampled and falls in the cycle after RESP.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0; release → stays IDLE with o_busy=0.
- Clean fill: i_miss=1, addr 0x0000_1234, memory returns 0xA000_0000+k on beat k, ack always high.
  - Required: read addresses 0x1200..0x123C in order.
  - Required: response in cycle 17 with line word k = 0xA000_0000+k.
- Dirty fill: i_evict=1, evict addr 0x0004_0040, evict data word k = 0x5A5A_0000+k, miss addr 0x0000_0080.
  - Required: 16 writes to 0x40040..0x4007C with matching data, then reads from 0x80..0xBC.
  - Required: response in cycle 33.
- Wait states: ack only every third cycle during FILL.
  - Required: address/data stable across stalls, no beat skipped or duplicated, response in cycle 1+48 = 49.
- Reset mid-fill: assert rst=0 after beat 7 → o_mem_req=0 at once and no response pulse; a fresh miss afterwards completes correctly.
- Back-to-back misses and stray acks: a second miss presented in the IDLE cycle right after RESP starts FILL in the next cycle. An i_mem_ack pulsed during IDLE causes no state or counter change.
